lab3_addr_sequencer: RTL and testbench
======================================

# lab3_addr_sequencer

Timed 5-bit address sequencer that drives the `A[4:0]`/`enable` inputs of the 5-to-32 decoder stage directly downstream. It steps through a programmable address window, up or down, dwelling a programmable number of cycles on each address. It runs either one-shot with a completion pulse or wrapping continuously. Used to scan the 32 decoder outputs, for example for LED chasers or row strobing, without a CPU.

## Interface
- `DIV_W`, 8, width of the dwell divider input.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; honoured only in IDLE.
- `stop`  in  1  abort; returns to IDLE from any state.
- `pause`  in  1  level; freezes the sequence while high.
- `mode_wrap`  in  1  1 = continuous wrap, 0 = one-shot.
- `dir`  in  1  0 = ascending, 1 = descending.
- `lo_addr`  in  5  window start address (ascending sense).
- `hi_addr`  in  5  window end address (ascending sense).
- `div`  in  DIV_W  dwell = `div`+1 cycles per address.
- `A`  out  5  address to the decoder.
- `enable`  out  1  decoder enable.
- `busy`  out  1  high in RUN or PAUSE.
- `done`  out  1  one-cycle pulse at one-shot completion.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- `start` latches `mode_wrap`, `dir`, `lo_addr`, `hi_addr` and `div`. Input changes during a scan have no effect.
- first = `dir` ? `hi_addr` : `lo_addr`; last = `dir` ? `lo_addr` : `hi_addr`. All address arithmetic is mod 32.
  - If `lo_addr` > `hi_addr`, the window wraps through 31→0.
  - Window length N = ((`hi_addr` − `lo_addr`) mod 32) + 1.
- IDLE, `start`=1 → RUN. `A`←first, `enable`←1, prescaler←0.
- RUN: the prescaler counts 0..div. A tick occurs when count == div; count then returns to 0.
  - On a tick with `A` ≠ last: `A`←`A`±1.
  - On a tick with `A` == last and wrap: `A`←first.
  - On a tick with `A` == last and one-shot: → DONE, `enable`←0.
- RUN, `pause`=1 → PAUSE. The tick is suppressed in that cycle, and the prescaler and `A` hold.
- PAUSE, `pause`=0 → RUN. The prescaler resumes from its held count. `enable` stays 1 throughout PAUSE.
- DONE: `done`=1 for exactly one cycle → IDLE. `A` keeps the last address.
- `stop`=1 in any state → IDLE next cycle, `enable`←0, `busy`←0, no `done` pulse. `stop` has priority over `start`, `pause` and tick.
- `start` outside IDLE is ignored. `start` and `stop` together in IDLE leave the block in IDLE.
- `lo_addr` == `hi_addr` gives a single-address scan of one dwell.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `A`=0, `enable`=0, `busy`=0, `done`=0, prescaler=0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `start` sampled at edge k → `A`=first, `enable`=1, `busy`=1 visible after edge k.
- Each address is held for `div`+1 cycles of RUN. PAUSE cycles add to this.
- One-shot: `enable` is high for exactly N×(`div`+1) cycles with no pause.
  - `done` is high in the following cycle, with `enable`=0 and `busy`=0.
  - A new `start` is accepted the cycle after `done`.
- `stop` sampled at edge k → `enable`=0 after edge k.
- Reset deasserting mid-scan yields IDLE. The scan does not resume.

## Structure
- Shared package/include `lab3_seq_pkg`:
  - state encodings (IDLE=0, RUN=1, PAUSE=2, DONE=3);
  - `ADDR_W`=5;
  - `ADDR_MAX`=31.
- One sub-module, `lab3_prescaler`:
  - `DIV_W` counter with `clr`, `en` and `div` inputs;
  - registered-free `tick` output = `en` && (count == `div`).
- The FSM and address register are in the top level. `A`/`enable` connect straight to the decoder's `A`/`enable`.

## Test plan
- Reset, then `div`=3, `lo_addr`=2, `hi_addr`=5, up, one-shot, `start` → `A`=2,3,4,5 each 4 cycles, `enable` high 16 cycles, single `done` pulse, then IDLE with `A`=5.
- `div`=0, `lo_addr`=30, `hi_addr`=1, `dir`=1, wrap → `A`=1,0,31,30,1,0… one per cycle, `done` never asserted, `busy` stays 1.
- `div`=1, `lo_addr`=`hi_addr`=0, one-shot → `A`=0 for 2 cycles, `done` in cycle 3.
- `pause` held 5 cycles mid-dwell, `div`=3 → `A` holds; the dwell of that address is 9 cycles total; the sequence then continues.
- `stop` and `start` together mid-scan, then `start` asserted with `lo_addr`=7 → IDLE with `enable`=0 and no `done`; the later `start` yields `A`=7.
- `rst_n` low mid-scan for 1 cycle → outputs zero immediately; after release the block stays IDLE.

Source files
------------

// File: rtl/lab3_seq_pkg.sv
// Shared types and constants for the lab3 address sequencer.
package lab3_seq_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ADDR_MAX = 5'd31;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } seq_state_e;

  // Next address in scan direction, wrapping mod 32.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a, input logic dir);
    if (dir) begin
      return (a == '0) ? ADDR_MAX : a - 1'b1;
    end
    return (a == ADDR_MAX) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/lab3_prescaler.sv
// Dwell prescaler: counts 0..div while enabled, tick on the terminal count.
module lab3_prescaler #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == i_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lab3_addr_sequencer.sv
// Timed 5-bit address sequencer driving a 5-to-32 decoder's address/enable inputs.
module lab3_addr_sequencer
  import lab3_seq_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_pause,
  input  logic              i_mode_wrap,
  input  logic              i_dir,
  input  logic [ADDR_W-1:0] i_lo_addr,
  input  logic [ADDR_W-1:0] i_hi_addr,
  input  logic [DIV_W-1:0]  i_div,
  output logic [ADDR_W-1:0] o_a,
  output logic              o_enable,
  output logic              o_busy,
  output logic              o_done
);

  seq_state_e        r_state;
  logic [ADDR_W-1:0] r_a;
  logic [ADDR_W-1:0] r_first;
  logic [ADDR_W-1:0] r_last;
  logic [DIV_W-1:0]  r_div;
  logic              r_wrap;
  logic              r_dir;
  logic              r_enable;
  logic              r_busy;
  logic              r_done;

  logic              w_pre_en;
  logic              w_pre_clr;
  logic              w_tick;
  logic [ADDR_W-1:0] w_first;
  logic [ADDR_W-1:0] w_last;

  assign w_first = i_dir ? i_hi_addr : i_lo_addr;
  assign w_last  = i_dir ? i_lo_addr : i_hi_addr;

  // The cycle that leaves PAUSE already counts, so a pause adds exactly its own length.
  assign w_pre_en  = ((r_state == StRun) || (r_state == StPause)) && !i_pause && !i_stop;
  assign w_pre_clr = (r_state == StIdle) || i_stop;

  lab3_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_pre_clr),
    .i_en   (w_pre_en),
    .i_div  (r_div),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_a      <= '0;
      r_first  <= '0;
      r_last   <= '0;
      r_div    <= '0;
      r_wrap   <= 1'b0;
      r_dir    <= 1'b0;
      r_enable <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_stop) begin
        r_state  <= StIdle;
        r_enable <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (i_start) begin
              r_state  <= StRun;
              r_first  <= w_first;
              r_last   <= w_last;
              r_div    <= i_div;
              r_wrap   <= i_mode_wrap;
              r_dir    <= i_dir;
              r_a      <= w_first;
              r_enable <= 1'b1;
              r_busy   <= 1'b1;
            end
          end
          StRun, StPause: begin
            if (i_pause) begin
              r_state <= StPause;
            end else begin
              r_state <= StRun;
              if (w_tick) begin
                if (r_a != r_last) begin
                  r_a <= step_addr(r_a, r_dir);
                end else if (r_wrap) begin
                  r_a <= r_first;
                end else begin
                  r_state  <= StDone;
                  r_enable <= 1'b0;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                end
              end
            end
          end
          StDone: r_state <= StIdle;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_a      = r_a;
  assign o_enable = r_enable;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: tb/tb_lab3_addr_sequencer.sv
// Directed self-checking bench for lab3_addr_sequencer.
module tb_lab3_addr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       mode_wrap = 1'b0;
  logic       dir = 1'b0;
  logic [4:0] lo_addr = '0;
  logic [4:0] hi_addr = '0;
  logic [7:0] div = '0;
  logic [4:0] a;
  logic       enable;
  logic       busy;
  logic       done;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  lab3_addr_sequencer #(
    .DIV_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (start),
    .i_stop      (stop),
    .i_pause     (pause),
    .i_mode_wrap (mode_wrap),
    .i_dir       (dir),
    .i_lo_addr   (lo_addr),
    .i_hi_addr   (hi_addr),
    .i_div       (div),
    .o_a         (a),
    .o_enable    (enable),
    .o_busy      (busy),
    .o_done      (done)
  );

  // Configure and pulse start; returns at the negedge of the first RUN cycle.
  task automatic launch(input logic w, input logic d, input logic [4:0] lo, input logic [4:0] hi,
                        input logic [7:0] dv);
    mode_wrap = w; dir = d; lo_addr = lo; hi_addr = hi; div = dv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    compared++; if (a !== 5'd0) begin mismatched++; $display("FAIL reset_a got %0d exp 0", a); end
    compared++; if (enable !== 1'b0) begin mismatched++; $display("FAIL reset_en got %b exp 0", enable); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b exp 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b exp 0", done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_oneshot_up;
    logic [4:0] exp_a;
    launch(1'b0, 1'b0, 5'd2, 5'd5, 8'd3);
    lo_addr = 5'd20; hi_addr = 5'd9; div = 8'd0; dir = 1'b1; // must be ignored mid-scan
    for (int i = 0; i < 16; i++) begin
      exp_a = 5'(2 + i / 4);
      compared++; if (a !== exp_a) begin mismatched++; $display("FAIL up_a[%0d] got %0d exp %0d", i, a, exp_a); end
      compared++; if (enable !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        mismatched++; $display("FAIL up_flags[%0d] en/busy/done got %b%b%b exp 110", i, enable, busy, done);
      end
      @(negedge clk);
    end
    compared++; if (done !== 1'b1 || enable !== 1'b0 || busy !== 1'b0) begin
      mismatched++; $display("FAIL up_done en/busy/done got %b%b%b exp 001", enable, busy, done);
    end
    compared++; if (a !== 5'd5) begin mismatched++; $display("FAIL up_hold_a got %0d exp 5", a); end
    @(negedge clk);
    compared++; if (done !== 1'b0 || enable !== 1'b0) begin
      mismatched++; $display("FAIL up_idle en/done got %b%b exp 00", enable, done);
    end
    compared++; if (a !== 5'd5) begin mismatched++; $display("FAIL up_idle_a got %0d exp 5", a); end
  endtask

  task automatic test_wrap_down;
    logic [4:0] seq [4];
    seq[0] = 5'd1; seq[1] = 5'd0; seq[2] = 5'd31; seq[3] = 5'd30;
    launch(1'b1, 1'b1, 5'd30, 5'd1, 8'd0);
    for (int i = 0; i < 10; i++) begin
      compared++; if (a !== seq[i % 4]) begin mismatched++; $display("FAIL wrap_a[%0d] got %0d exp %0d", i, a, seq[i % 4]); end
      compared++; if (busy !== 1'b1 || done !== 1'b0 || enable !== 1'b1) begin
        mismatched++; $display("FAIL wrap_flags[%0d] en/busy/done got %b%b%b exp 110", i, enable, busy, done);
      end
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    compared++; if (enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++; $display("FAIL wrap_stop en/busy/done got %b%b%b exp 000", enable, busy, done);
    end
    @(negedge clk);
  endtask

  task automatic test_single_addr;
    launch(1'b0, 1'b0, 5'd0, 5'd0, 8'd1);
    for (int i = 0; i < 2; i++) begin
      compared++; if (a !== 5'd0 || enable !== 1'b1 || done !== 1'b0) begin
        mismatched++; $display("FAIL single[%0d] a/en/done got %0d/%b/%b exp 0/1/0", i, a, enable, done);
      end
      @(negedge clk);
    end
    compared++; if (done !== 1'b1 || enable !== 1'b0 || a !== 5'd0) begin
      mismatched++; $display("FAIL single_done a/en/done got %0d/%b/%b exp 0/0/1", a, enable, done);
    end
    @(negedge clk);
  endtask

  task automatic test_pause;
    logic [4:0] exp_a;
    launch(1'b0, 1'b0, 5'd2, 5'd5, 8'd3);
    for (int i = 0; i < 13; i++) begin
      exp_a = (i < 9) ? 5'd2 : 5'd3;
      compared++; if (a !== exp_a) begin mismatched++; $display("FAIL pause_a[%0d] got %0d exp %0d", i, a, exp_a); end
      compared++; if (enable !== 1'b1 || busy !== 1'b1) begin
        mismatched++; $display("FAIL pause_flags[%0d] en/busy got %b%b exp 11", i, enable, busy);
      end
      if (i == 2) pause = 1'b1;
      if (i == 7) pause = 1'b0;
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stop_start;
    launch(1'b0, 1'b0, 5'd2, 5'd5, 8'd3);
    repeat (3) @(negedge clk);
    stop = 1'b1; start = 1'b1; lo_addr = 5'd7; hi_addr = 5'd9;
    @(negedge clk);
    compared++; if (enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++; $display("FAIL stop_mid en/busy/done got %b%b%b exp 000", enable, busy, done);
    end
    @(negedge clk);
    compared++; if (enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++; $display("FAIL stop_idle_both en/busy/done got %b%b%b exp 000", enable, busy, done);
    end
    stop = 1'b0;
    @(negedge clk);
    start = 1'b0;
    compared++; if (a !== 5'd7 || enable !== 1'b1 || busy !== 1'b1) begin
      mismatched++; $display("FAIL restart a/en/busy got %0d/%b/%b exp 7/1/1", a, enable, busy);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_scan;
    launch(1'b1, 1'b0, 5'd2, 5'd5, 8'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    compared++; if (a !== 5'd0 || enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++; $display("FAIL rst_async a/en/busy/done got %0d/%b/%b/%b exp 0/0/0/0", a, enable, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++; if (a !== 5'd0 || enable !== 1'b0 || busy !== 1'b0) begin
        mismatched++; $display("FAIL rst_stay_idle[%0d] a/en/busy got %0d/%b/%b exp 0/0/0", i, a, enable, busy);
      end
    end
  endtask

  initial begin
    test_reset;
    test_oneshot_up;
    test_wrap_down;
    test_single_addr;
    test_pause;
    test_stop_start;
    test_reset_mid_scan;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
